// File: rtl/fpnew_value_packer.sv
// fpnew_value_packer: two-stage pipelined encoder from {sign, signed exponent,
// integer mantissa} to a packed FpFormat value, round-to-nearest-even with
// saturation to max finite. Define FPNEW_PACK_FTZ_EN for flush-to-zero;
// otherwise subnormals are produced with gradual underflow.
// The minimal fpnew_pkg subset the packer depends on is carried in this file.

package fpnew_pkg;
  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef struct packed {
    int unsigned exp_bits;
    int unsigned man_bits;
  } fp_encoding_t;

  localparam int unsigned NUM_FP_FORMATS = 5;
  localparam fp_encoding_t [0:NUM_FP_FORMATS-1] FP_ENCODINGS = '{
    '{8, 23}, '{11, 52}, '{5, 10}, '{5, 2}, '{8, 7}
  };

  typedef struct packed {
    logic is_normal;
    logic is_subnormal;
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_signalling;
    logic is_quiet;
    logic is_boxed;
  } fp_info_t;

  function automatic int unsigned exp_bits(fp_format_e fmt);
    return FP_ENCODINGS[fmt].exp_bits;
  endfunction

  function automatic int unsigned man_bits(fp_format_e fmt);
    return FP_ENCODINGS[fmt].man_bits;
  endfunction

  function automatic int unsigned fp_width(fp_format_e fmt);
    return 1 + FP_ENCODINGS[fmt].exp_bits + FP_ENCODINGS[fmt].man_bits;
  endfunction

  function automatic int unsigned bias(fp_format_e fmt);
    return (2 ** (FP_ENCODINGS[fmt].exp_bits - 1)) - 1;
  endfunction
endpackage

module fpnew_value_packer #(
  parameter fpnew_pkg::fp_format_e FpFormat = fpnew_pkg::fp_format_e'(2),
  parameter int unsigned MAN_IN_WIDTH = 24,
  parameter int unsigned EXP_IN_WIDTH = 8,
  localparam int unsigned WIDTH = fpnew_pkg::fp_width(FpFormat)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic                    sign_i,
  input  logic [EXP_IN_WIDTH-1:0] exponent_i,
  input  logic [MAN_IN_WIDTH-1:0] mantissa_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [WIDTH-1:0]        result_o,
  output fpnew_pkg::fp_info_t     info_o,
  output logic                    of_o,
  output logic                    uf_o,
  output logic                    nx_o
);
  localparam int unsigned EXP_BITS = fpnew_pkg::exp_bits(FpFormat);
  localparam int unsigned MAN_BITS = fpnew_pkg::man_bits(FpFormat);
  localparam int unsigned BIAS     = fpnew_pkg::bias(FpFormat);
  localparam int unsigned M        = MAN_IN_WIDTH;
  localparam int unsigned BE_W     = EXP_IN_WIDTH + 2;
  localparam int unsigned LZC_W    = $clog2(M + 1);
  localparam int unsigned SH_W     = $clog2(M + 2);
  localparam int unsigned RW       = BE_W + MAN_BITS;

  localparam logic signed [BE_W-1:0] BE_ONE   = BE_W'(1);
  localparam logic signed [BE_W-1:0] BE_SHMAX = BE_W'(M + 1);
  localparam logic [BE_W-1:0]        MAX_BE   = BE_W'((1 << EXP_BITS) - 1);
  localparam logic [EXP_BITS-1:0]    MAX_EXP_FIELD = {{(EXP_BITS-1){1'b1}}, 1'b0};

  // Slot handshake: s2 drains to the consumer, s1 feeds s2.
  logic s1_valid, s2_valid, s1_load, s2_load;
  assign s2_load     = !s2_valid || out_ready_i;
  assign s1_load     = !s1_valid || s2_load;
  assign in_ready_o  = s1_load;
  assign out_valid_o = s2_valid;

  // ---------------- stage 1: normalize / denormalize ----------------
  logic [LZC_W-1:0]       lzc;
  logic                   lzc_found;
  logic signed [BE_W-1:0] exp_ext, lzc_ext, bias_ext, be_raw, shift_full;
  logic [M-1:0]           norm;
  logic [2*M-1:0]         wide;
  logic [SH_W-1:0]        sh;
  logic [M-1:0]           mant_next;
  logic                   sticky_next, tiny_next;
  logic [BE_W-1:0]        be_next;

  // Leading-zero count of the incoming mantissa.
  always_comb begin
    lzc       = '0;
    lzc_found = 1'b0;
    for (int i = M - 1; i >= 0; i--) begin
      if (!lzc_found) begin
        if (mantissa_i[i]) lzc_found = 1'b1;
        else               lzc = lzc + LZC_W'(1);
      end
    end
  end

  // Biased exponent, normalizing shift and the right shift into the subnormal range.
  always_comb begin
    exp_ext    = {{2{exponent_i[EXP_IN_WIDTH-1]}}, exponent_i};
    lzc_ext    = BE_W'(lzc);
    bias_ext   = BE_W'(BIAS);
    be_raw     = exp_ext - lzc_ext + bias_ext;
    norm       = mantissa_i << lzc;
    shift_full = BE_ONE - be_raw;
    sh         = (shift_full > BE_SHMAX) ? SH_W'(BE_SHMAX) : SH_W'(shift_full);
    wide       = {norm, {M{1'b0}}} >> sh;
    if (be_raw < BE_ONE) begin
      mant_next   = wide[2*M-1:M];
      sticky_next = |wide[M-1:0];
      tiny_next   = 1'b1;
      be_next     = '0;
    end else begin
      mant_next   = norm;
      sticky_next = 1'b0;
      tiny_next   = 1'b0;
      be_next     = be_raw;
    end
  end

  logic            s1_sign, s1_zero, s1_sticky, s1_tiny;
  logic [M-1:0]    s1_mant;
  logic [BE_W-1:0] s1_be;

  // Slot s1 register: captures the normalized beat when the slot advances.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_zero   <= 1'b0;
      s1_sticky <= 1'b0;
      s1_tiny   <= 1'b0;
      s1_mant   <= '0;
      s1_be     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_sign   <= sign_i;
        s1_zero   <= (mantissa_i == '0);
        s1_sticky <= sticky_next;
        s1_tiny   <= tiny_next;
        s1_mant   <= mant_next;
        s1_be     <= be_next;
      end
    end
  end

  // ---------------- stage 2: round / pack / classify ----------------
  logic [MAN_BITS-1:0] frac;
  logic                guard, sticky, round_up, inexact, overflow;
  logic [RW-1:0]       rounded;
  logic [BE_W-1:0]     rnd_be;
  logic [WIDTH-1:0]    res_next;
  logic                of_next, uf_next, nx_next;
  fpnew_pkg::fp_info_t info_next;

  // RNE on {exponent, fraction}: a fraction carry bumps the exponent, which
  // also lifts a subnormal into the minimum normal binade.
  always_comb begin
    frac     = s1_mant[M-2 -: MAN_BITS];
    guard    = s1_mant[M-2-MAN_BITS];
    sticky   = (|s1_mant[M-3-MAN_BITS:0]) | s1_sticky;
    round_up = guard & (sticky | frac[0]);
    inexact  = guard | sticky;
    rounded  = {s1_be, frac} + RW'(round_up);
    rnd_be   = rounded[RW-1:MAN_BITS];
    overflow = (rnd_be >= MAX_BE);
    res_next = '0;
    of_next  = 1'b0;
    uf_next  = 1'b0;
    nx_next  = 1'b0;
    if (s1_zero) begin
      res_next = {s1_sign, {(WIDTH-1){1'b0}}};
`ifdef FPNEW_PACK_FTZ_EN
    end else if (s1_tiny) begin
      res_next = {s1_sign, {(WIDTH-1){1'b0}}};
      uf_next  = 1'b1;
      nx_next  = 1'b1;
`endif
    end else if (overflow) begin
      res_next = {s1_sign, MAX_EXP_FIELD, {MAN_BITS{1'b1}}};
      of_next  = 1'b1;
      nx_next  = 1'b1;
    end else begin
      res_next = {s1_sign, rnd_be[EXP_BITS-1:0], rounded[MAN_BITS-1:0]};
      nx_next  = inexact;
      uf_next  = inexact & s1_tiny;
    end
  end

  // Class of the packed value, identical to what the operand classifier reports.
  always_comb begin
    info_next              = '0;
    info_next.is_boxed     = 1'b1;
    info_next.is_normal    = (res_next[WIDTH-2 -: EXP_BITS] != '0);
    info_next.is_subnormal = (res_next[WIDTH-2 -: EXP_BITS] == '0) && (res_next[MAN_BITS-1:0] != '0);
    info_next.is_zero      = (res_next[WIDTH-2:0] == '0);
  end

  // Slot s2 register: output stage, held stable while the consumer stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      result_o <= '0;
      info_o   <= '0;
      of_o     <= 1'b0;
      uf_o     <= 1'b0;
      nx_o     <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result_o <= res_next;
        info_o   <= info_next;
        of_o     <= of_next;
        uf_o     <= uf_next;
        nx_o     <= nx_next;
      end
    end
  end
endmodule

// File: tb/tb_fpnew_value_packer.sv
// Self-checking bench for fpnew_value_packer (FP16, 24-bit mantissa, 8-bit exponent).
// Honors FPNEW_PACK_FTZ_EN in its expectations.
`timescale 1ns/1ps
module tb_fpnew_value_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign = 1'b0;
  logic [7:0]  exponent = '0;
  logic [23:0] mantissa = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  fpnew_pkg::fp_info_t info;
  logic        of, uf, nx;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fpnew_value_packer dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .sign_i(sign), .exponent_i(exponent), .mantissa_i(mantissa),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .info_o(info),
    .of_o(of), .uf_o(uf), .nx_o(nx)
  );

  typedef struct {
    logic        s;
    int          e;
    int unsigned m;
    logic [15:0] r;
    logic [2:0]  f;   // {of, uf, nx}
  } vec_t;

  typedef struct {
    logic [15:0] r;
    logic [2:0]  f;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic real pow2(input int k);
    real v = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) v = v * 2.0;
    else        for (int i = 0; i < -k; i++) v = v * 0.5;
    return v;
  endfunction

  // Reference: exact value mant * 2^(exp-23), rounded RNE onto the FP16 grid.
  function automatic void ref_pack(input logic s, input int e_in, input int unsigned m,
                                   output logic [15:0] r, output logic [2:0] f);
    int  msb, e, ue, n, mag;
    bit  tiny, x;
    real q, rem;
    msb = -1;
    for (int i = 0; i < 24; i++) if (m[i]) msb = i;
    if (msb < 0) begin
      r = {s, 15'h0000};
      f = 3'b000;
      return;
    end
    e    = e_in + msb - 23;
    tiny = (e < -14);
    ue   = (tiny ? -14 : e) - 10;
    q    = real'(m) * pow2(e_in - 23 - ue);
    n    = $rtoi(q);
    rem  = q - real'(n);
    x    = (rem != 0.0);
    if (rem > 0.5 || (rem == 0.5 && (n % 2) == 1)) n++;
    mag  = tiny ? n : ((e + 15) * 1024 + (n - 1024));
`ifdef FPNEW_PACK_FTZ_EN
    if (tiny) begin
      r = {s, 15'h0000};
      f = 3'b011;
      return;
    end
`endif
    if (mag >= 'h7C00) begin
      r = {s, 15'h7BFF};
      f = 3'b101;
    end else begin
      r = {s, 15'(mag)};
      f = {1'b0, x && tiny, x};
    end
  endfunction

  function automatic fpnew_pkg::fp_info_t class_of(input logic [15:0] r);
    fpnew_pkg::fp_info_t c;
    c = '0;
    c.is_boxed = 1'b1;
    if (r[14:10] != 5'd0)     c.is_normal = 1'b1;
    else if (r[9:0] != 10'd0) c.is_subnormal = 1'b1;
    else                      c.is_zero = 1'b1;
    return c;
  endfunction

  // One beat into an empty pipeline; reports latency in rising edges counted
  // from the capturing edge (2 = visible in the cycle after next).
  task automatic apply_single(input string name, input logic s, input int e, input int unsigned m,
                              input logic [15:0] r_req, input logic [2:0] f_req);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    sign = s; exponent = 8'(e); mantissa = 24'(m); in_valid = 1'b1;
    #1;
    check({name, "_accept"}, 64'(in_ready), 64'(1));
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      #1;
    end
    check({name, "_latency"}, 64'(lat), 64'(2));
    check({name, "_result"}, 64'(result), 64'(r_req));
    check({name, "_flags"}, 64'({of, uf, nx}), 64'(f_req));
    check({name, "_info"}, 64'(info), 64'(class_of(r_req)));
    $display("vec %s: s=%0d e=%0d m=%06h -> %04h of/uf/nx=%03b lat=%0d",
             name, s, e, m, result, {of, uf, nx}, lat);
  endtask

  vec_t vecs[$];
  exp_t exp_q[$];

  initial begin
    // ---------------- reset state ----------------
    #2;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_info", 64'(info), 64'(0));
    check("rst_flags", 64'({of, uf, nx}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // ---------------- directed vector table ----------------
    vecs.push_back('{1'b0,   0, 24'h800000, 16'h3C00, 3'b000});
    vecs.push_back('{1'b0,   0, 24'h801000, 16'h3C00, 3'b001});
    vecs.push_back('{1'b0,   0, 24'h803000, 16'h3C02, 3'b001});
    vecs.push_back('{1'b0,  16, 24'h800000, 16'h7BFF, 3'b101});
    vecs.push_back('{1'b1,  16, 24'h800000, 16'hFBFF, 3'b101});
    vecs.push_back('{1'b1,   0, 24'h000000, 16'h8000, 3'b000});
    vecs.push_back('{1'b0, -14, 24'h800000, 16'h0400, 3'b000});
    vecs.push_back('{1'b1, -30, 24'h800000, 16'h8000, 3'b011});
    vecs.push_back('{1'b0,   0, 24'hFFF000, 16'h4000, 3'b001});
    vecs.push_back('{1'b0,  15, 24'hFFF000, 16'h7BFF, 3'b101});
    vecs.push_back('{1'b0,  15, 24'hFFE000, 16'h7BFF, 3'b000});
    vecs.push_back('{1'b1,   1, 24'h803000, 16'hC002, 3'b001});
    vecs.push_back('{1'b0, -25, 24'h800000, 16'h0000, 3'b011});
    vecs.push_back('{1'b0,   3, 24'h000C00, 16'h1A00, 3'b000});
`ifdef FPNEW_PACK_FTZ_EN
    vecs.push_back('{1'b0,   0, 24'h000001, 16'h0000, 3'b011});
    vecs.push_back('{1'b0, -15, 24'hFFFFFF, 16'h0000, 3'b011});
    vecs.push_back('{1'b0, -24, 24'h800000, 16'h0000, 3'b011});
`else
    vecs.push_back('{1'b0,   0, 24'h000001, 16'h0002, 3'b000});
    vecs.push_back('{1'b0, -15, 24'hFFFFFF, 16'h0400, 3'b011});
    vecs.push_back('{1'b0, -24, 24'h800000, 16'h0001, 3'b000});
`endif
    for (int i = 0; i < vecs.size(); i++)
      apply_single($sformatf("v%0d", i), vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].r, vecs[i].f);

    // ---------------- backpressure: 3 beats against a stalled consumer ----------------
    @(negedge clk);
    out_ready = 1'b0;
    sign = 1'b0; exponent = 8'd0; mantissa = 24'h800000; in_valid = 1'b1;   // A = 1.0
    #1;
    check("bp_ready_a", 64'(in_ready), 64'(1));
    @(negedge clk);
    exponent = 8'd1; mantissa = 24'h800000;                                  // B = 2.0
    #1;
    check("bp_ready_b", 64'(in_ready), 64'(1));
    @(negedge clk);
    exponent = 8'd1; mantissa = 24'hC00000;                                  // C = 3.0
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready_drop", 64'(in_ready), 64'(0));
      check("bp_hold_valid", 64'(out_valid), 64'(1));
      check("bp_hold_result", 64'(result), 64'(16'h3C00));
      $display("bp stall cycle %0d: result %04h in_ready %0d", k, result, in_ready);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'(1));
    check("bp_out_a", 64'(result), 64'(16'h3C00));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("bp_out_b_valid", 64'(out_valid), 64'(1));
    check("bp_out_b", 64'(result), 64'(16'h4000));
    @(negedge clk);
    #1;
    check("bp_out_c_valid", 64'(out_valid), 64'(1));
    check("bp_out_c", 64'(result), 64'(16'h4200));
    $display("bp drained: last result %04h", result);
    @(negedge clk);
    #1;
    check("bp_empty", 64'(out_valid), 64'(0));

    // ---------------- asynchronous reset with both slots full ----------------
    @(negedge clk);
    out_ready = 1'b0;
    sign = 1'b1; exponent = 8'd2; mantissa = 24'h900000; in_valid = 1'b1;
    @(negedge clk);
    mantissa = 24'hA00000;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("rf_full_ready", 64'(in_ready), 64'(0));
    check("rf_full_valid", 64'(out_valid), 64'(1));
    #1;
    rst = 1'b1;
    #1;
    check("rf_async_valid", 64'(out_valid), 64'(0));
    check("rf_async_result", 64'(result), 64'(0));
    check("rf_async_info", 64'(info), 64'(0));
    check("rf_async_flags", 64'({of, uf, nx}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rf_post_ready", 64'(in_ready), 64'(1));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("rf_no_stale", 64'(out_valid), 64'(0));
    end
    $display("reset mid-flight: pipeline empty after release");
    apply_single("rf_new", 1'b0, 0, 24'h800000, 16'h3C00, 3'b000);

    // ---------------- randomized traffic against the reference model ----------------
    for (int cyc = 0; cyc < 800; cyc++) begin
      int          e;
      int unsigned m;
      exp_t        x;
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      e = int'($urandom_range(0, 75)) - 45;
      m = ($urandom() & 32'h00FF_FFFF) >> $urandom_range(0, 24);
      if ($urandom_range(0, 3) == 0) m = (m & 32'hFFFF_E000) | 32'h0000_1000;
      sign = $urandom_range(0, 1);
      exponent = 8'(e);
      mantissa = 24'(m);
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("rnd_spurious_valid", 64'(out_valid), 64'(0));
        end else begin
          check("rnd_result", 64'(result), 64'(exp_q[0].r));
          check("rnd_flags", 64'({of, uf, nx}), 64'(exp_q[0].f));
          check("rnd_info", 64'(info), 64'(class_of(exp_q[0].r)));
          if (out_ready) begin
            $display("rnd out: %04h of/uf/nx=%03b", result, {of, uf, nx});
            void'(exp_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        ref_pack(sign, e, m, x.r, x.f);
        exp_q.push_back(x);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      #1;
      if (out_valid) begin
        check("rnd_drain_result", 64'(result), 64'(exp_q[0].r));
        check("rnd_drain_flags", 64'({of, uf, nx}), 64'(exp_q[0].f));
        $display("rnd drain: %04h", result);
        void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    check("rnd_all_emitted", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
